// File: rtl/queen_pkg.sv
// Shared types and constants for the N-queens response checker.
package queen_pkg;

  localparam int N_DEF  = 12;
  localparam int DIAG_W = 5;

  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_RANGE   = 3'd1,
    ERR_GIVEN   = 3'd2,
    ERR_ROW     = 3'd3,
    ERR_DIAG    = 3'd4,
    ERR_SHORT   = 3'd5,
    ERR_LONG    = 3'd6,
    ERR_TIMEOUT = 3'd7
  } err_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    COLLECT,
    REPORT
  } state_e;

endpackage

// File: rtl/queen_conflict_tracker.sv
// Row and diagonal occupancy masks for the queens placed so far in one solution.
module queen_conflict_tracker
  import queen_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       mark,
  input  logic [3:0] col,
  input  logic [3:0] row,
  output logic       row_hit,
  output logic       diag_hit
);

  localparam int D = 2 * N - 1;

  logic [N-1:0]      row_used;
  logic [D-1:0]      diag_a;
  logic [D-1:0]      diag_b;
  logic [DIAG_W-1:0] idx_a;
  logic [DIAG_W-1:0] idx_b;
  logic              row_ok;
  logic              a_ok;
  logic              b_ok;

  // Out-of-range rows produce indices past the masks; those are masked off here.
  assign idx_a  = DIAG_W'(row) + DIAG_W'(col);
  assign idx_b  = DIAG_W'(row) + DIAG_W'(N - 1) - DIAG_W'(col);
  assign row_ok = int'(row) < N;
  assign a_ok   = int'(idx_a) < D;
  assign b_ok   = int'(idx_b) < D;

  assign row_hit  = row_ok && row_used[row];
  assign diag_hit = (a_ok && diag_a[idx_a]) || (b_ok && diag_b[idx_b]);

  always_ff @(posedge clk) begin
    if (clear) begin
      row_used <= '0;
      diag_a   <= '0;
      diag_b   <= '0;
    end else if (mark) begin
      if (row_ok) row_used[row] <= 1'b1;
      if (a_ok)   diag_a[idx_a] <= 1'b1;
      if (b_ok)   diag_b[idx_b] <= 1'b1;
    end
  end

endmodule

// File: rtl/queen_checker.sv
// Incremental legality checker for N-queens solver output with pass/fail counters.
module queen_checker
  import queen_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_valid_num,
  input  logic [2:0]       in_num,
  input  logic [3:0]       col,
  input  logic [3:0]       row,
  input  logic             out_valid,
  input  logic [3:0]       out,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  N4      = 4'(N);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e        state;
  logic [3:0]    count;
  logic [TW-1:0] tcnt;
  err_e          err_q;
  logic [N-1:0]  given_vld;
  logic [3:0]    given_row [N];
  logic [2:0]    num_q;
  logic          unused_num;

  logic          beat;
  logic [3:0]    cidx;
  logic          row_hit;
  logic          diag_hit;
  err_e          beat_err;
  logic          fin_go;
  err_e          fin_err;

  function automatic err_e keep_first(input err_e held, input err_e nxt);
    return (held != ERR_OK) ? held : nxt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The queen count is kept for debug only; it never gates a result.
  assign unused_num = ^num_q;

  assign beat = out_valid && ((state == WAIT) || (state == COLLECT && count < N4));
  assign cidx = (state == COLLECT && count < N4) ? count : 4'd0;

  queen_conflict_tracker #(.N(N)) u_tracker (
    .clk      (clk),
    .clear    (rst || state == IDLE),
    .mark     (beat),
    .col      (cidx),
    .row      (out),
    .row_hit  (row_hit),
    .diag_hit (diag_hit)
  );

  always_comb begin
    beat_err = ERR_OK;
    if (int'(out) >= N)                                 beat_err = ERR_RANGE;
    else if (given_vld[cidx] && out != given_row[cidx]) beat_err = ERR_GIVEN;
    else if (row_hit)                                   beat_err = ERR_ROW;
    else if (diag_hit)                                  beat_err = ERR_DIAG;
  end

  always_comb begin
    fin_go  = 1'b0;
    fin_err = ERR_OK;
    case (state)
      WAIT: begin
        if (!out_valid && tcnt == TO_LAST) begin
          fin_go  = 1'b1;
          fin_err = ERR_TIMEOUT;
        end
      end
      COLLECT: begin
        if (out_valid && count == N4) begin
          fin_go  = 1'b1;
          fin_err = keep_first(err_q, ERR_LONG);
        end else if (!out_valid) begin
          fin_go  = 1'b1;
          fin_err = (count == N4) ? err_q : keep_first(err_q, ERR_SHORT);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      tcnt      <= '0;
      err_q     <= ERR_OK;
      given_vld <= '0;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      err_code  <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      err_code  <= '0;
      if (fin_go) begin
        state     <= REPORT;
        chk_valid <= 1'b1;
        chk_pass  <= (fin_err == ERR_OK);
        err_code  <= fin_err;
        if (fin_err == ERR_OK) pass_cnt <= sat_inc(pass_cnt);
        else                   fail_cnt <= sat_inc(fail_cnt);
      end else begin
        case (state)
          IDLE: begin
            given_vld <= '0;
            err_q     <= ERR_OK;
            count     <= '0;
            if (in_valid && in_valid_num) begin
              num_q <= in_num;
              if (int'(col) < N) begin
                given_vld[col] <= 1'b1;
                given_row[col] <= row;
              end
              state <= LOAD;
            end
          end
          LOAD: begin
            if (in_valid) begin
              if (int'(col) < N) begin
                given_vld[col] <= 1'b1;
                given_row[col] <= row;
              end
            end else begin
              tcnt  <= '0;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (out_valid) begin
              err_q <= beat_err;
              count <= 4'd1;
              state <= COLLECT;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          COLLECT: begin
            err_q <= keep_first(err_q, beat_err);
            count <= count + 1'b1;
          end
          REPORT:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_queen_checker.sv
// Table-driven, hand-sequenced and randomized checks of queen_checker against a board-level model.
module tb_queen_checker;

  localparam int N    = 12;
  localparam int TO   = 20;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_valid_num = 1'b0;
  logic [2:0]    in_num = 3'd0;
  logic [3:0]    col = 4'd0;
  logic [3:0]    row = 4'd0;
  logic          out_valid = 1'b0;
  logic [3:0]    out = 4'd0;
  logic          chk_valid;
  logic          chk_pass;
  logic [2:0]    err_code;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;

  queen_checker #(.N(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_valid_num (in_valid_num),
    .in_num       (in_num),
    .col          (col),
    .row          (row),
    .out_valid    (out_valid),
    .out          (out),
    .chk_valid    (chk_valid),
    .chk_pass     (chk_pass),
    .err_code     (err_code),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int pass;
    int err;
    int pc;
    int fc;
  } rep_t;
  rep_t rep_q[$];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int ng;
    int gc0, gr0, gc1, gr1;
    int len;
    int k1, v1, k2, v2;
    int exp;
  } vec_t;
  vec_t tbl[8];

  int g_col[6];
  int g_row[6];
  int ng;
  int slen;
  int sout[13];
  int pass_m = 0;
  int fail_m = 0;
  int sol[12] = '{1, 3, 5, 7, 9, 11, 0, 2, 4, 6, 8, 10};

  always @(negedge clk) begin
    if (!rst) begin
      if (chk_valid) begin
        rep_q.push_back('{cyc, int'(chk_pass), int'(err_code), int'(pass_cnt), int'(fail_cnt)});
      end else begin
        total++;
        if (chk_pass !== 1'b0 || err_code !== 3'd0) begin
          bad++;
          $display("FAIL idle_quiet cyc=%0d actual pass=%0b err=%0d required pass=0 err=0",
                   cyc, chk_pass, err_code);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Board variants: mirrored rows and/or reversed columns of one legal solution.
  task automatic load_sol(input int variant);
    for (int k = 0; k < N; k++) begin
      int r;
      r = variant[1] ? sol[N - 1 - k] : sol[k];
      sout[k] = variant[0] ? (N - 1 - r) : r;
    end
    sout[12] = 0;
    slen = N;
  endtask

  function automatic int model_err();
    int gmap[N];
    int lim;
    for (int c = 0; c < N; c++) gmap[c] = -1;
    for (int i = 0; i < ng; i++) gmap[g_col[i]] = g_row[i];
    lim = (slen < N) ? slen : N;
    for (int k = 0; k < lim; k++) begin
      int v;
      v = sout[k];
      if (v >= N) return 1;
      if (gmap[k] >= 0 && v != gmap[k]) return 2;
      for (int j = 0; j < k; j++) if (sout[j] == v) return 3;
      for (int j = 0; j < k; j++) begin
        int d;
        d = (sout[j] > v) ? sout[j] - v : v - sout[j];
        if (d == k - j) return 4;
      end
    end
    if (slen < N) return 5;
    if (slen > N) return 6;
    return 0;
  endfunction

  task automatic drive_given(output int s);
    s = cyc;
    for (int i = 0; i < ng; i++) begin
      in_valid     = 1'b1;
      in_valid_num = (i == 0);
      in_num       = 3'(ng);
      col          = 4'(g_col[i]);
      row          = 4'(g_row[i]);
      s = cyc;
      tick();
    end
    in_valid     = 1'b0;
    in_valid_num = 1'b0;
  endtask

  task automatic drive_outs(output int t);
    t = cyc;
    for (int k = 0; k < slen; k++) begin
      out_valid = 1'b1;
      out       = 4'(sout[k]);
      tick();
    end
    out_valid = 1'b0;
    out       = 4'd0;
  endtask

  task automatic await_report(input string nm, input int exp_cyc, input int exp_err);
    int waited;
    rep_t r;
    waited = 0;
    while (rep_q.size() == 0 && waited < 60) begin
      tick();
      waited++;
    end
    if (rep_q.size() == 0) begin
      check({nm, "_report_seen"}, 0, 1);
      return;
    end
    repeat (3) tick();
    if (exp_err == 0) pass_m = (pass_m < MAXC) ? pass_m + 1 : pass_m;
    else              fail_m = (fail_m < MAXC) ? fail_m + 1 : fail_m;
    r = rep_q[0];
    check({nm, "_nreports"}, rep_q.size(), 1);
    check({nm, "_cycle"}, r.c, exp_cyc);
    check({nm, "_err"}, r.err, exp_err);
    check({nm, "_pass"}, r.pass, (exp_err == 0) ? 1 : 0);
    check({nm, "_pass_cnt"}, r.pc, pass_m);
    check({nm, "_fail_cnt"}, r.fc, fail_m);
    rep_q.delete();
  endtask

  task automatic run_pattern(input string nm, input int gap, input int exp_err);
    int s, t;
    rep_q.delete();
    drive_given(s);
    repeat (gap) tick();
    drive_outs(t);
    await_report(nm, t + ((slen < N) ? slen : N) + 1, exp_err);
  endtask

  task automatic apply_vec(input vec_t v);
    ng = v.ng;
    g_col[0] = v.gc0; g_row[0] = v.gr0;
    g_col[1] = v.gc1; g_row[1] = v.gr1;
    load_sol(0);
    slen = v.len;
    if (v.k1 >= 0) sout[v.k1] = v.v1;
    if (v.k2 >= 0) sout[v.k2] = v.v2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    //            ng gc0 gr0 gc1 gr1 len  k1 v1  k2 v2  exp
    tbl[0] = '{2, 0, 1, 6, 0, 12, -1, 0, -1, 0, 0};  // legal
    tbl[1] = '{2, 0, 1, 6, 0, 12,  0, 3, -1, 0, 2};  // given mismatch
    tbl[2] = '{2, 0, 1, 6, 0, 12,  4, 1,  7, 13, 3}; // row first, range later
    tbl[3] = '{2, 0, 1, 6, 0, 11, -1, 0, -1, 0, 5};  // short
    tbl[4] = '{2, 0, 1, 6, 0, 13, 12, 0, -1, 0, 6};  // long
    tbl[5] = '{1, 0, 1, 0, 1, 12,  1, 2, -1, 0, 4};  // diagonal
    tbl[6] = '{2, 0, 1, 6, 0, 12,  0, 12, -1, 0, 1}; // range before given
    tbl[7] = '{2, 0, 5, 0, 1, 12, -1, 0, -1, 0, 0};  // duplicate column, last wins

    repeat (3) tick();
    check("rst_chk_valid", int'(chk_valid), 0);
    check("rst_chk_pass", int'(chk_pass), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_pass_cnt", int'(pass_cnt), 0);
    check("rst_fail_cnt", int'(fail_cnt), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      apply_vec(tbl[i]);
      run_pattern($sformatf("vec%0d", i), 1, tbl[i].exp);
    end

    // Timeout: no solver output after the given queens.
    apply_vec(tbl[0]);
    rep_q.delete();
    drive_given(s);
    await_report("timeout", s + TO + 2, 7);
    apply_vec(tbl[0]);
    run_pattern("after_timeout", 2, 0);

    for (int it = 0; it < 30; it++) begin
      int r;
      load_sol(int'($urandom_range(0, 3)));
      ng = int'($urandom_range(1, 6));
      for (int i = 0; i < ng; i++) begin
        g_col[i] = int'($urandom_range(0, N - 1));
        g_row[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : sout[g_col[i]];
      end
      if ($urandom_range(0, 2) == 0) sout[$urandom_range(0, N - 1)] = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 5));
      slen = (r == 0) ? 11 : (r == 1) ? 13 : 12;
      run_pattern($sformatf("rand%0d", it), int'($urandom_range(1, 4)), model_err());
    end

    // Reset in the middle of a solution stream: nothing reported, counters cleared.
    apply_vec(tbl[0]);
    rep_q.delete();
    drive_given(s);
    tick();
    for (int k = 0; k < 5; k++) begin
      out_valid = 1'b1;
      out       = 4'(sout[k]);
      tick();
    end
    out_valid = 1'b1;
    out       = 4'(sout[5]);
    rst       = 1'b1;
    tick();
    out_valid = 1'b0;
    rst       = 1'b0;
    pass_m    = 0;
    fail_m    = 0;
    repeat (20) tick();
    check("midrst_no_report", rep_q.size(), 0);
    check("midrst_pass_cnt", int'(pass_cnt), 0);
    check("midrst_fail_cnt", int'(fail_cnt), 0);
    apply_vec(tbl[0]);
    run_pattern("after_midrst", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
